// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: CPU stores to TXDATA feed a small FIFO,
// and STATUS exposes FIFO/line state through a one-cycle registered read port.
module uart_tx_mmio #(
  parameter logic [31:0] BASE     = 32'h0000_1000,
  parameter int          DEPTH    = 8,
  parameter int          BAUD_DIV = 16
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] address_i,
  input  logic [31:0] wdata_i,
  input  logic        write_i,
  output logic        sel_o,
  output logic [31:0] rdata_o,
  output logic        tx_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [31:0]   rdData_q, rdData_d;
  state_e        state_q, state_d;
  logic [BW-1:0] baudCnt_q, baudCnt_d;
  logic [2:0]    bitCnt_q, bitCnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;

  logic       validAcc, isStatus, txWrite, full, empty;
  logic       push, drop, pop, clrOvf, baudDone;
  logic [3:0] countExt;
  logic [31:0] statusWord;
  logic       unusedWdata;

  assign sel_o      = (address_i[31:3] == BASE[31:3]);
  assign validAcc   = sel_o && (address_i[1:0] == 2'b00);
  assign isStatus   = address_i[2];
  assign txWrite    = validAcc && write_i && !isStatus;
  assign full       = (count_q == CW'(DEPTH));
  assign empty      = (count_q == '0);
  // Fullness is judged on the registered count, so a same-cycle pop never rescues a push.
  assign push       = txWrite && !full;
  assign drop       = txWrite && full;
  assign clrOvf     = validAcc && write_i && isStatus && wdata_i[3];
  assign pop        = (state_q == IDLE) && !empty;
  assign baudDone   = (baudCnt_q == BW'(BAUD_DIV - 1));
  assign countExt   = 4'(count_q);
  assign statusWord = {24'h0, countExt, overflow_q, (state_q != IDLE), empty, full};
  assign unusedWdata = ^wdata_i[31:8];

  assign rdata_o = rdData_q;
  assign tx_o    = tx_q;

  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    rdData_d   = '0;
    if (push) wrPtr_d = wrPtr_q + PW'(1);
    if (pop)  rdPtr_d = rdPtr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (clrOvf) overflow_d = 1'b0;
    if (drop)   overflow_d = 1'b1;
    if (validAcc && !write_i && isStatus) rdData_d = statusWord;
  end

  // tx is derived from the current state, which places the line one cycle behind the FSM.
  always_comb begin
    state_d   = state_q;
    baudCnt_d = baudCnt_q;
    bitCnt_d  = bitCnt_q;
    shift_d   = shift_q;
    tx_d      = 1'b1;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          shift_d   = mem_q[rdPtr_q];
          baudCnt_d = '0;
          bitCnt_d  = '0;
          state_d   = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (baudDone) begin
          baudCnt_d = '0;
          state_d   = DATA;
        end else begin
          baudCnt_d = baudCnt_q + BW'(1);
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (baudDone) begin
          baudCnt_d = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          bitCnt_d  = bitCnt_q + 3'd1;
          if (bitCnt_q == 3'd7) state_d = STOP;
        end else begin
          baudCnt_d = baudCnt_q + BW'(1);
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (baudDone) begin
          baudCnt_d = '0;
          state_d   = IDLE;
        end else begin
          baudCnt_d = baudCnt_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rdData_q   <= '0;
      state_q    <= IDLE;
      baudCnt_q  <= '0;
      bitCnt_q   <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      rdData_q   <= rdData_d;
      state_q    <= state_d;
      baudCnt_q  <= baudCnt_d;
      bitCnt_q   <= bitCnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
    end
  end

  // Storage needs no reset: pointers and count alone decide what is valid.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wrPtr_q] <= wdata_i[7:0];
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: directed scenarios plus random writes, with the line and
// STATUS predicted from a frame-schedule model (pop edge, frame span, byte data).
module tb_uart_tx_mmio;

  localparam logic [31:0] BASE   = 32'h0000_1000;
  localparam int          DEPTH  = 8;
  localparam int          BAUD   = 4;
  localparam int          FRAME  = 10 * BAUD;
  localparam int          PERIOD = FRAME + 1;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [31:0] address_i;
  logic [31:0] wdata_i;
  logic        write_i;
  logic        sel_o;
  logic [31:0] rdata_o;
  logic        tx_o;

  int total = 0;
  int bad = 0;
  int edgeCnt = 0;

  int         pushQ[$];
  int         popQ[$];
  logic [7:0] dataQ[$];
  bit         modelOvf;

  uart_tx_mmio #(.BASE(BASE), .DEPTH(DEPTH), .BAUD_DIV(BAUD)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .address_i(address_i), .wdata_i(wdata_i),
    .write_i(write_i), .sel_o(sel_o), .rdata_o(rdata_o), .tx_o(tx_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit inWindow(input logic [31:0] a);
    return a[31:3] == BASE[31:3];
  endfunction

  function automatic int modelCount(input int w);
    int c = 0;
    foreach (popQ[i]) if (pushQ[i] < w && popQ[i] >= w) c++;
    return c;
  endfunction

  function automatic bit modelActive(input int w);
    foreach (popQ[i]) if (w >= popQ[i] + 1 && w <= popQ[i] + FRAME) return 1'b1;
    return 1'b0;
  endfunction

  // A frame popped at edge P drives the line after edges P+1..P+FRAME.
  function automatic logic modelTx(input int t);
    int k;
    foreach (popQ[i]) begin
      if (t >= popQ[i] + 1 && t <= popQ[i] + FRAME) begin
        k = (t - popQ[i] - 1) / BAUD;
        if (k == 0) return 1'b0;
        if (k <= 8) return dataQ[i][k-1];
        return 1'b1;
      end
    end
    return 1'b1;
  endfunction

  function automatic logic [31:0] modelStatus(input int w);
    int c;
    logic [3:0] c4;
    c = modelCount(w);
    c4 = 4'(c);
    return {24'h0, c4, modelOvf, modelActive(w), (c == 0), (c == DEPTH)};
  endfunction

  task automatic modelReset();
    pushQ.delete();
    popQ.delete();
    dataQ.delete();
    modelOvf = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    edgeCnt++;
    @(negedge clk_i);
    checkOutput($sformatf("tx@%0d", edgeCnt), {31'b0, tx_o}, {31'b0, modelTx(edgeCnt)});
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input bit wr);
    int w;
    int p;
    address_i = addr;
    wdata_i   = data;
    write_i   = wr;
    #1 checkOutput("sel", {31'b0, sel_o}, {31'b0, inWindow(addr)});
    w = edgeCnt + 1;
    if (wr && inWindow(addr) && addr[1:0] == 2'b00) begin
      if (!addr[2]) begin
        if (modelCount(w) == DEPTH) modelOvf = 1'b1;
        else begin
          p = w + 1;
          if (popQ.size() > 0 && popQ[$] + PERIOD > p) p = popQ[$] + PERIOD;
          pushQ.push_back(w);
          popQ.push_back(p);
          dataQ.push_back(data[7:0]);
        end
      end else if (data[3]) begin
        modelOvf = 1'b0;
      end
    end
    tick();
    address_i = 32'h0;
    wdata_i   = 32'h0;
    write_i   = 1'b0;
  endtask

  task automatic readReg(input logic [31:0] addr, input string tag, output logic [31:0] obs);
    logic [31:0] exp;
    exp = (inWindow(addr) && addr[1:0] == 2'b00 && addr[2]) ? modelStatus(edgeCnt + 1) : 32'h0;
    applyStimulus(addr, 32'h0, 1'b0);
    obs = rdata_o;
    checkOutput(tag, obs, exp);
  endtask

  task automatic drain();
    int endEdge;
    endEdge = edgeCnt;
    if (popQ.size() > 0 && popQ[$] + FRAME + 2 > endEdge) endEdge = popQ[$] + FRAME + 2;
    while (edgeCnt < endEdge) tick();
  endtask

  initial begin
    logic [31:0] obs;
    int n;
    int p0;

    address_i = 32'h0;
    wdata_i   = 32'h0;
    write_i   = 1'b0;
    reset_i   = 1'b0;
    modelReset();
    #2 reset_i = 1'b1;
    @(negedge clk_i);
    repeat (3) tick();
    checkOutput("rdata_in_reset", rdata_o, 32'h0);
    reset_i = 1'b0;

    $display("[TB] reset state");
    readReg(BASE + 32'h4, "status_after_reset", obs);
    checkOutput("status_after_reset_const", obs, 32'h0000_0002);

    $display("[TB] single byte");
    n = edgeCnt + 1;
    applyStimulus(BASE, 32'h55, 1'b1);
    while (edgeCnt < n + 42) begin
      tick();
      if (edgeCnt == n + 1)  checkOutput("pre_start_high", {31'b0, tx_o}, 32'h1);
      if (edgeCnt == n + 2)  checkOutput("start_low", {31'b0, tx_o}, 32'h0);
      if (edgeCnt == n + 6)  checkOutput("bit0_one", {31'b0, tx_o}, 32'h1);
      if (edgeCnt == n + 10) checkOutput("bit1_zero", {31'b0, tx_o}, 32'h0);
      if (edgeCnt == n + 38) checkOutput("stop_high", {31'b0, tx_o}, 32'h1);
    end
    readReg(BASE + 32'h4, "status_after_byte", obs);
    checkOutput("status_after_byte_const", obs, 32'h0000_0002);

    $display("[TB] overflow");
    for (int i = 1; i <= 10; i++) applyStimulus(BASE, 32'(i), 1'b1);
    readReg(BASE + 32'h4, "status_overflow", obs);
    checkOutput("status_overflow_const", obs, 32'h0000_008D);
    applyStimulus(BASE + 32'h4, 32'h0, 1'b1);
    readReg(BASE + 32'h4, "status_ovf_kept", obs);
    checkOutput("ovf_kept_bit", {31'b0, obs[3]}, 32'h1);
    applyStimulus(BASE + 32'h4, 32'h8, 1'b1);
    readReg(BASE + 32'h4, "status_ovf_cleared", obs);
    checkOutput("ovf_cleared_bit", {31'b0, obs[3]}, 32'h0);
    drain();

    $display("[TB] reset mid-frame");
    applyStimulus(BASE, 32'h00, 1'b1);
    p0 = popQ[$];
    applyStimulus(BASE, 32'hFF, 1'b1);
    applyStimulus(BASE, 32'h3C, 1'b1);
    applyStimulus(BASE, 32'hA5, 1'b1);
    while (edgeCnt < p0 + 18) tick();
    reset_i = 1'b1;
    #1 checkOutput("tx_async_reset", {31'b0, tx_o}, 32'h1);
    modelReset();
    repeat (2) tick();
    reset_i = 1'b0;
    readReg(BASE + 32'h4, "status_after_abort", obs);
    checkOutput("status_after_abort_const", obs, 32'h0000_0002);
    repeat (100) tick();

    $display("[TB] decode");
    applyStimulus(BASE + 32'h1, 32'hAA, 1'b1);
    readReg(BASE + 32'h4, "status_misaligned_write", obs);
    checkOutput("misaligned_no_push", obs, 32'h0000_0002);
    applyStimulus(32'h0000_0000, 32'h77, 1'b1);
    readReg(BASE + 32'h4, "status_outside_write", obs);
    checkOutput("outside_no_push", obs, 32'h0000_0002);
    readReg(BASE + 32'h8, "read_outside", obs);
    readReg(BASE, "read_txdata", obs);
    readReg(BASE + 32'h5, "read_misaligned", obs);
    repeat (10) tick();

    $display("[TB] random traffic");
    for (int i = 0; i < 30; i++) begin
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(30, 60) : $urandom_range(0, 3);
      repeat (n) tick();
      applyStimulus(BASE, 32'($urandom_range(0, 255)), 1'b1);
      if ($urandom_range(0, 3) == 0) readReg(BASE + 32'h4, "rand_status", obs);
      if ($urandom_range(0, 5) == 0) applyStimulus(BASE + 32'h4, 32'h8, 1'b1);
    end
    drain();
    readReg(BASE + 32'h4, "final_status", obs);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter that sits on the CPU data bus next to the RAM and debug register. It consumes CPU stores to its address window, buffers bytes in a small FIFO, and serialises them 8N1 on a single `tx` pin. The top level muxes its registered read data onto the CPU `data_in` using `sel`, the same way it muxes RAM.

## Interface
- `BASE`, 32'h0000_1000: window base, 8-byte aligned; TXDATA at BASE+0, STATUS at BASE+4.
- `DEPTH`, 8: FIFO entries; power of two, 2..8.
- `BAUD_DIV`, 16: clocks per bit; ≥2.

Ports:
- `clk` in 1: the single clock, the CPU clock.
- `reset` in 1: asynchronous, active-high.
- `address` in 32: CPU byte address.
- `wdata` in 32: CPU store data (CPU `data_out`).
- `write` in 1: CPU store strobe, single cycle, no wait states.
- `sel` out 1: combinational, `address[31:3] == BASE[31:3]`.
- `rdata` out 32: registered read data.
- `tx` out 1: serial line, idle high.

## Operation
- Access valid only when `sel` and `address[1:0]==0`. Misaligned accesses are ignored: no push, no clear, and `rdata` reads 0.
- TXDATA write: push `wdata[7:0]` if not full. If full, the byte is dropped and sticky `overflow` is set. "Full" is the registered count before any same-cycle pop, so a push while full is dropped even if a pop happens that cycle.
- TXDATA read returns 0.
- STATUS read:
  - bit0 full
  - bit1 empty
  - bit2 active (FSM not IDLE)
  - bit3 overflow
  - bits[7:4] count (0..DEPTH)
  - rest 0
- STATUS write: `wdata[3]=1` clears overflow. Other bits are ignored. If a clear and an overflowing push coincide (impossible on one bus, but defined), set wins.
- FIFO: circular, read/write pointers wrap mod DEPTH. Count updates +1 on push, −1 on pop, unchanged on simultaneous push and pop.
- TX FSM states IDLE, START, DATA, STOP:
  - IDLE: `tx=1`. If count≠0, pop the head into the shift register, clear the baud and bit counters, go to START.
  - START: `tx=0` for BAUD_DIV cycles, then go to DATA.
  - DATA: `tx`=shift[0], LSB first. Each bit lasts BAUD_DIV cycles, then shift right. After 8 bits, go to STOP.
  - STOP: `tx=1` for BAUD_DIV cycles, then go to IDLE.
- `tx` is registered, never combinational.

## Timing
- Reset values: `tx=1`, `rdata=0`, count 0, pointers 0, overflow 0, state IDLE, counters 0. `sel` is purely combinational.
- Reset asserted mid-frame: `tx` goes 1 asynchronously, the frame is aborted and queued bytes are discarded.
- Read latency is 1 cycle, matching RAM. With address presented in cycle N, `rdata` is valid in N+1. Cycles without a valid read load `rdata <= 0`. STATUS returns state sampled at edge N.
- Write at edge N: count reflects it from N+1.
- Empty FIFO and IDLE: write at N, pop at N+1, `tx` falls at N+2.
- Frame length is exactly 10×BAUD_DIV cycles of line activity, followed by exactly 1 IDLE cycle (`tx=1`) before the next start bit when data is queued.
- Maximum sustained rate is one byte per 10×BAUD_DIV+1 cycles.

## Test plan
Directed scenarios, with BAUD_DIV=4 and DEPTH=8:
- **Reset state:** reset, then read 0x1004 → `rdata` 0x0000_0002 next cycle; `tx`=1; `sel`=1.
- **Single byte:** write 0x1000=0x55 at N.
  - `tx` low during N+2..N+5.
  - Bits 1,0,1,0,1,0,1,0, 4 cycles each.
  - Stop high during N+38..N+41.
  - STATUS then reads 0x02.
- **Overflow:** 10 back-to-back writes 0x01..0x0A at N..N+9.
  - 0x0A is dropped.
  - STATUS read at N+10 → 0x8D.
  - Line emits 0x01..0x09 in order, with 1 idle cycle between frames.
- **Overflow clear:**
  - Write 0x1004=0x0 → overflow stays set.
  - Write 0x1004=0x8 → bit3 reads 0.
- **Reset mid-frame:** assert reset during DATA bit 3 with 3 bytes queued → `tx`=1 immediately; after release STATUS=0x02 and no further frames.
- **Decode:**
  - Write 0x1001=0xAA → no push, count 0.
  - Write 0x0000=0x77 → `sel`=0, no push.
  - Read 0x1008 → `sel`=0.
